// File: rtl/spi_xfer_pkg.sv
// Shared types for the SPI transfer sequencer.
package spi_xfer_pkg;
  localparam int SPI_BYTE_W = 8;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, FLUSH} xfer_state_e;
endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Request / TX byte / RX byte / status bundle between a client and spi_xfer_ctrl.
interface spi_xfer_ctrl_if import spi_xfer_pkg::*; #(parameter int LW = 8) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [LW-1:0]         req_len;
  logic                  abort;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [SPI_BYTE_W-1:0] rx_data;
  logic                  xfer_done;
  logic                  xfer_err;

  modport slave (
    input  req_valid, req_len, abort, tx_valid, tx_data, rx_ready,
    output req_ready, tx_ready, rx_valid, rx_data, xfer_done, xfer_err
  );

  modport master (
    output req_valid, req_len, abort, tx_valid, tx_data, rx_ready,
    input  req_ready, tx_ready, rx_valid, rx_data, xfer_done, xfer_err
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Transfer sequencer in front of an SPI master: streams N bytes into its TX FIFO and
// N bytes out of its RX FIFO with credit flow control. Optional watchdog: SPI_XFER_TIMEOUT_EN.
module spi_xfer_ctrl import spi_xfer_pkg::*; #(
  parameter int FAW = 3,
  parameter int LW  = 8,
  parameter int TOW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_xfer_ctrl_if.slave        xif,
  output logic                  spi_enable,
  output logic                  spi_wr,
  output logic [SPI_BYTE_W-1:0] spi_datai,
  output logic                  spi_rd,
  input  logic [SPI_BYTE_W-1:0] spi_datao,
  input  logic                  spi_done,
  input  logic                  spi_busy,
  output logic                  spi_tx_flush,
  output logic                  spi_rx_flush
);
  localparam int DEPTH = 2**FAW;

  xfer_state_e   state, state_nxt;
  logic [LW-1:0] len_q, pushed, popped, inflight;
  logic [FAW:0]  rx_avail;
  logic          active, accept, push, pop, flush, time_out;
  logic [TOW-1:0] to_cnt;

  // Bytes pushed but not yet popped; bounding this by DEPTH keeps both SPI FIFOs safe.
  assign inflight = pushed - popped;
  assign active   = (state == RUN) || (state == DRAIN);
  assign accept   = (state == IDLE) && xif.req_valid;

  assign xif.req_ready = (state == IDLE);
  assign xif.tx_ready  = (state == RUN) && (pushed < len_q) && (int'(inflight) < DEPTH) && !xif.abort;
  assign push          = xif.tx_valid && xif.tx_ready;
  assign xif.rx_valid  = active && (rx_avail != '0) && !xif.abort;
  assign pop           = xif.rx_valid && xif.rx_ready;
  assign xif.rx_data   = spi_datao;

  assign spi_enable = active;
  assign spi_wr     = push;
  assign spi_datai  = push ? xif.tx_data : '0;
  assign spi_rd     = pop;

  assign flush         = (state == FLUSH) && !spi_busy;
  assign spi_tx_flush  = flush;
  assign spi_rx_flush  = flush;
  assign xif.xfer_err  = flush;
  assign xif.xfer_done = (state == DONE);

`ifdef SPI_XFER_TIMEOUT_EN
  // Watchdog: counts stalled cycles while bytes are outstanding; any completed byte restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt <= '0;
    else if (!active || spi_done) to_cnt <= '0;
    else if (inflight != '0)     to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_cnt = '0;
`endif
  assign time_out = active && (&to_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xif.req_valid) state_nxt = (xif.req_len == '0) ? DONE : RUN;
      RUN:     if (xif.abort || time_out) state_nxt = FLUSH;
               else if (pushed == len_q)  state_nxt = DRAIN;
      DRAIN:   if (xif.abort || time_out) state_nxt = FLUSH;
               else if (popped == len_q)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      FLUSH:   if (!spi_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rx_avail counts bytes already sitting in the RX FIFO; a spi_done is credited one cycle late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= '0;
      pushed   <= '0;
      popped   <= '0;
      rx_avail <= '0;
    end else if (accept) begin
      len_q    <= xif.req_len;
      pushed   <= '0;
      popped   <= '0;
      rx_avail <= '0;
    end else if (active && !xif.abort) begin
      pushed   <= pushed + LW'(push);
      popped   <= popped + LW'(pop);
      rx_avail <= rx_avail + (FAW+1)'(spi_done) - (FAW+1)'(pop);
    end
  end
endmodule
